// File: rtl/imm_gen_pipe_pkg.sv
// Shared format codes, opcode constants and XLEN legality check for imm_gen_pipe.
// CSR immediate decode is enabled by defining IMM_GEN_ZIMM_EN.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'b000,
        FMT_U     = 3'b001,
        FMT_I     = 3'b010,
        FMT_SHIFT = 3'b011,
        FMT_B     = 3'b100,
        FMT_S     = 3'b101,
        FMT_J     = 3'b110,
        FMT_ZIMM  = 3'b111
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic bit xlenLegal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between upstream/downstream and imm_gen_pipe; master drives
// the instruction stream and downstream ready, slave is the immediate generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_tgt;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tgt, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tgt, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe_imm_dec.sv
// Combinational RV immediate decoder: format from the opcode, sign/zero-extended
// immediate and illegal flag. ZIMM decode present only with IMM_GEN_ZIMM_EN.
module imm_dec
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    fmt_e       w_fmt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        w_fmt = FMT_NONE;
        imm   = '0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_fmt = FMT_U;
                imm   = sext({instr[31:12], 12'b0});
            end
            OPC_LOAD, OPC_JALR: begin
                w_fmt = FMT_I;
                imm   = sext({{20{instr[31]}}, instr[31:20]});
            end
            OPC_OPIMM: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_fmt = FMT_SHIFT;
                    // RV64 shift amounts carry one more bit than RV32
                    imm   = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
                end else begin
                    w_fmt = FMT_I;
                    imm   = sext({{20{instr[31]}}, instr[31:20]});
                end
            end
            OPC_BRANCH: begin
                w_fmt = FMT_B;
                imm   = sext({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
            end
            OPC_STORE: begin
                w_fmt = FMT_S;
                imm   = sext({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            OPC_JAL: begin
                w_fmt = FMT_J;
                imm   = sext({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
                if (w_funct3[2]) begin
                    w_fmt = FMT_ZIMM;
                    imm   = XLEN'(instr[19:15]);
                end else begin
                    w_fmt = FMT_I;
                    imm   = sext({{20{instr[31]}}, instr[31:20]});
                end
`else
                w_fmt = FMT_I;
                imm   = sext({{20{instr[31]}}, instr[31:20]});
`endif
            end
            default: begin
                w_fmt = FMT_NONE;
                imm   = '0;
            end
        endcase

        // Compressed or otherwise non-32-bit encodings are rejected outright
        if (instr[1:0] != 2'b11) begin
            w_fmt = FMT_NONE;
            imm   = '0;
        end
    end

    assign fmt     = w_fmt;
    assign illegal = (w_fmt == FMT_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a one-entry skid buffer and PC+imm target adder.
// Define IMM_GEN_ZIMM_EN to enable CSR immediate (ZIMM) decode.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    imm_gen_pipe_if.slave      bus
);

    if (!xlenLegal(XLEN)) begin : g_badXlen
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] w_decImm;
    logic [2:0]      w_decFmt;
    logic            w_decIllegal;
    entry_t          w_newEntry;
    logic            w_accept;
    logic            w_outFree;
    logic            w_skidValidNext;

    entry_t r_out;
    entry_t r_skid;
    logic   r_outValid;
    logic   r_skidValid;
    logic   r_inReady;

    imm_dec #(.XLEN(XLEN)) u_immDec (
        .instr   (bus.in_instr),
        .imm     (w_decImm),
        .fmt     (w_decFmt),
        .illegal (w_decIllegal)
    );

    assign w_newEntry.imm     = w_decImm;
    assign w_newEntry.tgt     = bus.in_pc + w_decImm;
    assign w_newEntry.fmt     = w_decFmt;
    assign w_newEntry.illegal = w_decIllegal;

    assign w_accept        = bus.in_valid && r_inReady;
    assign w_outFree       = !r_outValid || bus.out_ready;
    assign w_skidValidNext = w_outFree ? 1'b0 : (r_skidValid || w_accept);

    // Skid always refills the output first so entries stay in FIFO order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_skid      <= '0;
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else if (bus.flush) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else begin
            if (w_outFree) begin
                if (r_skidValid) begin
                    r_out       <= r_skid;
                    r_outValid  <= 1'b1;
                    r_skidValid <= 1'b0;
                end else if (w_accept) begin
                    r_out      <= w_newEntry;
                    r_outValid <= 1'b1;
                end else begin
                    r_outValid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid      <= w_newEntry;
                r_skidValid <= 1'b1;
            end
            r_inReady <= !w_skidValidNext;
        end
    end

    assign bus.in_ready    = r_inReady;
    assign bus.out_valid   = r_outValid;
    assign bus.out_imm     = r_out.imm;
    assign bus.out_tgt     = r_out.tgt;
    assign bus.out_fmt     = r_out.fmt;
    assign bus.out_illegal = r_out.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances); ZIMM
// expectations follow IMM_GEN_ZIMM_EN.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

    always #5 clk = ~clk;

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic rdy, input logic fl);
        bus32.in_valid  = v;
        bus32.in_instr  = instr;
        bus32.in_pc     = pc;
        bus32.out_ready = rdy;
        bus32.flush     = fl;
        stepClock();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkEntry32(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                                input logic [31:0] tgt, input logic ill);
        checkOutput({tag, ".valid"},   64'(bus32.out_valid), 64'd1);
        checkOutput({tag, ".imm"},     64'(bus32.out_imm), 64'(imm));
        checkOutput({tag, ".fmt"},     64'(bus32.out_fmt), 64'(fmt));
        checkOutput({tag, ".tgt"},     64'(bus32.out_tgt), 64'(tgt));
        checkOutput({tag, ".illegal"}, 64'(bus32.out_illegal), 64'(ill));
    endtask

    initial begin
        logic [31:0] instrS;
        logic [31:0] instrJ;
        instrS = {7'h7F, 5'd1, 5'd2, 3'b010, 5'b11100, 7'b0100011};
        instrJ = {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111};

        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0;
        bus32.out_ready = 1'b0; bus32.flush = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0;
        bus64.out_ready = 1'b1; bus64.flush = 1'b0;

        rst = 1'b1;
        stepClock();
        stepClock();
        checkOutput("rst.valid",   64'(bus32.out_valid), 64'd0);
        checkOutput("rst.ready",   64'(bus32.in_ready), 64'd1);
        checkOutput("rst.imm",     64'(bus32.out_imm), 64'd0);
        checkOutput("rst.tgt",     64'(bus32.out_tgt), 64'd0);
        checkOutput("rst.fmt",     64'(bus32.out_fmt), 64'd0);
        checkOutput("rst.illegal", 64'(bus32.out_illegal), 64'd0);
        rst = 1'b0;

        bus64.in_valid = 1'b1; bus64.in_instr = 32'h03F0_9093; bus64.in_pc = 64'h0;
        stepClock();
        checkOutput("x64.slli.imm", bus64.out_imm, 64'd63);
        checkOutput("x64.slli.fmt", 64'(bus64.out_fmt), 64'd3);
        bus64.in_instr = 32'hFE00_0EE3; bus64.in_pc = 64'h200;
        stepClock();
        checkOutput("x64.beq.imm", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("x64.beq.tgt", bus64.out_tgt, 64'h1FC);
        bus64.in_valid = 1'b0;

        applyStimulus(1'b1, 32'h0010_0093, 32'h100, 1'b1, 1'b0);
        checkEntry32("addi", 32'd1, 3'b010, 32'h101, 1'b0);
        applyStimulus(1'b1, 32'hFE00_0EE3, 32'h200, 1'b1, 1'b0);
        checkEntry32("beq", 32'hFFFF_FFFC, 3'b100, 32'h1FC, 1'b0);
        applyStimulus(1'b1, 32'h03F0_9093, 32'h0, 1'b1, 1'b0);
        checkEntry32("slli32", 32'd31, 3'b011, 32'd31, 1'b0);
        applyStimulus(1'b1, 32'h1234_5037, 32'h10, 1'b1, 1'b0);
        checkEntry32("lui", 32'h1234_5000, 3'b001, 32'h1234_5010, 1'b0);
        applyStimulus(1'b1, instrS, 32'h40, 1'b1, 1'b0);
        checkEntry32("sw", 32'hFFFF_FFFC, 3'b101, 32'h3C, 1'b0);
        applyStimulus(1'b1, instrJ, 32'h1000, 1'b1, 1'b0);
        checkEntry32("jal", 32'h800, 3'b110, 32'h1800, 1'b0);
        applyStimulus(1'b1, 32'h0200_0093, 32'hFFFF_FFF0, 1'b1, 1'b0);
        checkEntry32("wrap", 32'h20, 3'b010, 32'h10, 1'b0);
        applyStimulus(1'b1, 32'h0000_0000, 32'h80, 1'b1, 1'b0);
        checkEntry32("zero", 32'd0, 3'b000, 32'h80, 1'b1);
        applyStimulus(1'b1, 32'h0010_0091, 32'h80, 1'b1, 1'b0);
        checkEntry32("len16", 32'd0, 3'b000, 32'h80, 1'b1);
        applyStimulus(1'b1, 32'h0002_D073, 32'h0, 1'b1, 1'b0);
`ifdef IMM_GEN_ZIMM_EN
        checkEntry32("csrwi", 32'd5, 3'b111, 32'd5, 1'b0);
`else
        checkEntry32("csrwi", 32'd0, 3'b010, 32'd0, 1'b0);
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("idle.valid", 64'(bus32.out_valid), 64'd0);

        applyStimulus(1'b1, 32'h0010_0093, 32'h300, 1'b0, 1'b0);
        checkOutput("stall1.ready", 64'(bus32.in_ready), 64'd1);
        applyStimulus(1'b1, 32'h0020_0093, 32'h300, 1'b0, 1'b0);
        checkOutput("stall2.ready", 64'(bus32.in_ready), 64'd0);
        checkOutput("stall2.imm",   64'(bus32.out_imm), 64'd1);
        applyStimulus(1'b1, 32'h0030_0093, 32'h300, 1'b0, 1'b0);
        checkOutput("stall3.ready", 64'(bus32.in_ready), 64'd0);
        checkEntry32("stall3.hold", 32'd1, 3'b010, 32'h301, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkEntry32("drainB", 32'd2, 3'b010, 32'h302, 1'b0);
        checkOutput("drainB.ready", 64'(bus32.in_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("drained.valid", 64'(bus32.out_valid), 64'd0);

        applyStimulus(1'b1, 32'h0010_0093, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0020_0093, 32'h0, 1'b0, 1'b0);
        checkOutput("full.ready", 64'(bus32.in_ready), 64'd0);
        applyStimulus(1'b1, 32'h0070_0093, 32'h0, 1'b0, 1'b1);
        checkOutput("flush.valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("flush.ready", 64'(bus32.in_ready), 64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("postflush.valid", 64'(bus32.out_valid), 64'd0);

        applyStimulus(1'b1, 32'h0010_0093, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0020_0093, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0030_0093, 32'h0, 1'b1, 1'b1);
        checkOutput("rststall.valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("rststall.ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("rststall.imm",   64'(bus32.out_imm), 64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("postrst.valid", 64'(bus32.out_valid), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath width; legal values are 32 and 64 only, and any other value SHALL stop elaboration.
REQ-002 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  upstream holds a valid instruction.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 in_instr  input  32  raw RV instruction word.
REQ-008 in_pc  input  XLEN  PC of in_instr.
REQ-009 out_valid  output  1  output entry valid.
REQ-010 out_ready  input  1  downstream accepts the output entry.
REQ-011 out_imm  output  XLEN  decoded immediate.
REQ-012 out_fmt  output  3  format code.
REQ-013 out_tgt  output  XLEN  in_pc + out_imm, modulo 2^XLEN.
REQ-014 out_illegal  output  1  opcode or length is not recognised.

Function
REQ-015 The format SHALL be derived from in_instr[6:0] with no select input:
- 0110111/0010111 -> U (001)
- 0000011/1100111 -> I (010)
- 0010011 with funct3 001/101 -> SHIFT (011); other funct3 -> I (010)
- 1100011 -> B (100)
- 0100011 -> S (101)
- 1101111 -> J (110)
- anything else -> NONE (000)
REQ-016 Immediate construction, all sign-extended from instr[31] to XLEN:
- U = {instr[31:12], 12'b0}
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
REQ-017 SHIFT zero-extends instr[24:20] when XLEN=32, and zero-extends instr[25:20] when XLEN=64.
REQ-018 For NONE, out_imm SHALL be 0 and out_illegal SHALL be 1.
REQ-019 When instr[1:0] is not 11, the entry SHALL be forced to NONE with out_illegal=1.
REQ-020 out_tgt SHALL be computed for every format and SHALL wrap on overflow.
REQ-021 An instruction SHALL be accepted on in_valid && in_ready and SHALL appear on the outputs exactly 1 cycle later; outputs SHALL be registered.
REQ-022 Storage SHALL be one output register plus one skid entry, giving 2 entries total.
REQ-023 in_ready SHALL be a register output and SHALL equal "skid entry empty".
REQ-024 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-025 An acceptance while the output is stalled SHALL fill the skid entry, and in_ready SHALL drop on the next cycle.
REQ-026 When the output drains and the skid entry is full, the skid entry SHALL move to the output register in the same edge, and in_ready SHALL rise on the next cycle.
REQ-027 Simultaneous accept and drain with an empty skid entry SHALL load the output register directly; throughput SHALL be 1 per cycle.
REQ-028 Ordering SHALL be strictly FIFO; no entry SHALL be dropped or duplicated.
REQ-029 flush SHALL clear out_valid and the skid entry at the edge; an instruction presented in the same cycle SHALL be dropped; in_ready SHALL be 1 in the following cycle.

Reset
REQ-030 rst SHALL set out_valid=0, the skid entry to empty, in_ready=1, out_imm=0, out_tgt=0, out_fmt=000 and out_illegal=0.
REQ-031 rst SHALL override flush and any handshake in the same cycle.
REQ-032 rst asserted mid-stall SHALL discard both entries.

Configuration
REQ-033 The macro IMM_GEN_ZIMM_EN SHALL control CSR immediate decode:
- Defined: opcode 1110011 with funct3[2]=1 -> ZIMM (111), imm = zero-extended instr[19:15], out_illegal=0; other SYSTEM funct3 values -> I.
- Undefined: all of opcode 1110011 -> I, and code 111 SHALL never be produced.

Structure
REQ-034 A shared package SHALL hold the format codes (NONE/U/I/SHIFT/B/S/J/ZIMM), the opcode constants and the XLEN legality check.
REQ-035 The combinational decoder SHALL be a sub-module imm_dec (instr in; imm, fmt, illegal out; parameter XLEN); imm_gen_pipe instantiates it once and owns the registers, skid entry and adder.

Verification
REQ-036 The bench SHALL cover:
- 32'h0010_0093 (addi x1,x0,1), pc=0x100 -> next cycle: imm=1, fmt=010, tgt=0x101, illegal=0.
- 32'hFE00_0EE3 (beq, offset -4), pc=0x200 -> imm=0xFFFF_FFFC, fmt=100, tgt=0x1FC.
- XLEN=64 with 32'h03F0_9093 (slli x1,x1,63) -> imm=63, fmt=011.
- out_ready=0 and 3 back-to-back valid inputs -> 2 accepted, in_ready=0 from the cycle after the 2nd acceptance; release -> outputs in order, with no loss or duplication.
- flush while both entries are full and in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the flushed-cycle input never appears.
- 32'h0000_0000 -> fmt=000, imm=0, illegal=1; 32'h0002_D073 (csrwi) -> fmt=111, imm=5 with IMM_GEN_ZIMM_EN defined, and fmt=010 without it.
